// File: rtl/ad_pkg.sv
// Shared definitions for the dual-channel ADC window averager.
package ad_pkg;

    localparam int AD_W = 12;

    localparam logic [AD_W-1:0] CLIP_LO = 12'h000;
    localparam logic [AD_W-1:0] CLIP_HI = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // A sample pinned at either rail means the front end was saturated.
    function automatic logic is_clip(input logic [AD_W-1:0] sample);
        return (sample == CLIP_LO) || (sample == CLIP_HI);
    endfunction

endpackage

// File: rtl/ad_avg_ch.sv
// One channel of the averager: window accumulator, clip sticky bit and the
// published average/clip registers.
module ad_avg_ch
    import ad_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic            clk50m,
    input  logic            reset_n,
    input  logic [AD_W-1:0] sample,
    input  logic            acc_en,
    input  logic            clear,
    input  logic            publish,
    output logic [AD_W-1:0] avg,
    output logic            clip
);

    localparam int ACC_W = AD_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_reg;
    logic             sticky_reg;

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg    <= '0;
            sticky_reg <= 1'b0;
            avg        <= '0;
            clip       <= 1'b0;
        end else begin
            // Publish reads the pre-clear accumulator, so both may fire together.
            if (publish) begin
                avg  <= acc_reg[AVG_LOG2 +: AD_W];
                clip <= sticky_reg;
            end
            if (clear) begin
                acc_reg    <= '0;
                sticky_reg <= 1'b0;
            end else if (acc_en) begin
                acc_reg    <= acc_reg + {{AVG_LOG2{1'b0}}, sample};
                sticky_reg <= sticky_reg | is_clip(sample);
            end
        end
    end

endmodule

// File: rtl/ad_avg.sv
// Dual-channel ADC averager: strobe divider and window FSM driving two
// per-channel accumulate/divide slices.
module ad_avg
    import ad_pkg::*;
#(
    parameter int AVG_LOG2 = 4,
    parameter int DIV      = 50
) (
    input  logic            clk50m,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [AD_W-1:0] ad_ch1,
    input  logic [AD_W-1:0] ad_ch2,
    output logic [AD_W-1:0] avg_ch1,
    output logic [AD_W-1:0] avg_ch2,
    output logic            avg_valid,
    output logic            clip_ch1,
    output logic            clip_ch2,
    output logic            busy
);

    localparam int              DIV_W    = 16;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_t              state_reg, state_next;
    logic [DIV_W-1:0]    div_cnt_reg;
    logic [AVG_LOG2-1:0] smp_cnt_reg;
    logic                avg_valid_reg;
    logic                strobe;
    logic                last_sample;
    logic                acc_en, clear, publish;

    assign strobe      = enable && (div_cnt_reg == DIV_LAST);
    assign last_sample = strobe && (smp_cnt_reg == {AVG_LOG2{1'b1}});

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_reg <= '0;
        end else if (!enable || div_cnt_reg == DIV_LAST) begin
            div_cnt_reg <= '0;
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            smp_cnt_reg <= '0;
        end else if (state_reg != ACC) begin
            smp_cnt_reg <= '0;
        end else if (strobe) begin
            smp_cnt_reg <= smp_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE:    state_next = ACC;
                ACC:     state_next = last_sample ? OUT : ACC;
                OUT:     state_next = ACC;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        acc_en  = (state_reg == ACC) && strobe;
        clear   = (state_reg != ACC);
        publish = (state_reg == OUT);
        busy    = (state_reg != IDLE);
    end

    // The pulse lands on the same edge the slices load their outputs.
    always_ff @(posedge clk50m or negedge reset_n) begin
        if (!reset_n) begin
            avg_valid_reg <= 1'b0;
        end else begin
            avg_valid_reg <= publish;
        end
    end

    assign avg_valid = avg_valid_reg;

    ad_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_ch1 (
        .clk50m  (clk50m),
        .reset_n (reset_n),
        .sample  (ad_ch1),
        .acc_en  (acc_en),
        .clear   (clear),
        .publish (publish),
        .avg     (avg_ch1),
        .clip    (clip_ch1)
    );

    ad_avg_ch #(.AVG_LOG2(AVG_LOG2)) u_ch2 (
        .clk50m  (clk50m),
        .reset_n (reset_n),
        .sample  (ad_ch2),
        .acc_en  (acc_en),
        .clear   (clear),
        .publish (publish),
        .avg     (avg_ch2),
        .clip    (clip_ch2)
    );

endmodule

// File: tb/tb_ad_avg.sv
// Directed bench for ad_avg with AVG_LOG2=4, DIV=2 (one strobe every 2 clocks).
module tb_ad_avg;

    localparam int AVG_LOG2 = 4;
    localparam int DIV      = 2;

    logic        clk50m = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [11:0] ad_ch1, ad_ch2;
    logic [11:0] avg_ch1, avg_ch2;
    logic        avg_valid, clip_ch1, clip_ch2, busy;

    always #5 clk50m = ~clk50m;

    ad_avg #(.AVG_LOG2(AVG_LOG2), .DIV(DIV)) dut (
        .clk50m    (clk50m),
        .reset_n   (reset_n),
        .enable    (enable),
        .ad_ch1    (ad_ch1),
        .ad_ch2    (ad_ch2),
        .avg_ch1   (avg_ch1),
        .avg_ch2   (avg_ch2),
        .avg_valid (avg_valid),
        .clip_ch1  (clip_ch1),
        .clip_ch2  (clip_ch2),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [11:0] s1 [32];
    logic [11:0] s2 [32];

    logic [11:0] q_avg1 [$];
    logic [11:0] q_avg2 [$];
    logic        q_clip1 [$];
    logic        q_clip2 [$];
    int          q_cyc [$];

    always @(posedge clk50m) cyc <= cyc + 1;

    // Record every published window, one line per pulse.
    always @(negedge clk50m) begin
        if (avg_valid === 1'b1) begin
            q_avg1.push_back(avg_ch1);
            q_avg2.push_back(avg_ch2);
            q_clip1.push_back(clip_ch1);
            q_clip2.push_back(clip_ch2);
            q_cyc.push_back(cyc);
            $display("pulse cyc=%0d avg_ch1=%h avg_ch2=%h clip_ch1=%b clip_ch2=%b",
                     cyc, avg_ch1, avg_ch2, clip_ch1, clip_ch2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_q();
        q_avg1.delete();
        q_avg2.delete();
        q_clip1.delete();
        q_clip2.delete();
        q_cyc.delete();
    endtask

    // Called at a negedge; each sample is held across the 2-clock strobe period.
    task automatic feed(input int n);
        enable = 1'b1;
        for (int k = 0; k < n; k++) begin
            ad_ch1 = s1[k];
            ad_ch2 = s2[k];
            @(posedge clk50m);
            @(posedge clk50m);
            @(negedge clk50m);
        end
    endtask

    task automatic idle_gap();
        enable = 1'b0;
        repeat (4) @(negedge clk50m);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b0;
        ad_ch1  = '0;
        ad_ch2  = '0;
        repeat (2) @(negedge clk50m);
        n_checks++; if (avg_ch1 !== 12'h000) $display("FAIL reset_avg1: got %h want 000", avg_ch1); else n_pass++;
        n_checks++; if (avg_ch2 !== 12'h000) $display("FAIL reset_avg2: got %h want 000", avg_ch2); else n_pass++;
        n_checks++; if (avg_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", avg_valid); else n_pass++;
        n_checks++; if (clip_ch1 !== 1'b0) $display("FAIL reset_clip1: got %b want 0", clip_ch1); else n_pass++;
        n_checks++; if (clip_ch2 !== 1'b0) $display("FAIL reset_clip2: got %b want 0", clip_ch2); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk50m);
    endtask

    task automatic test_const();
        int c0;
        int i;
        clear_q();
        ad_ch1 = 12'h800;
        ad_ch2 = 12'h800;
        c0     = cyc;
        enable = 1'b1;
        i = 0;
        while (q_cyc.size() < 2 && i < 200) begin
            @(posedge clk50m);
            i++;
        end
        @(negedge clk50m);
        n_checks++; if (busy !== 1'b1) $display("FAIL const_busy: got %b want 1", busy); else n_pass++;
        n_checks++;
        if (q_cyc.size() < 2) begin
            $display("FAIL const_pulses: got %0d pulses want 2 within 200 clocks", q_cyc.size());
        end else begin
            n_pass++;
            n_checks++; if (q_cyc[0] - c0 !== 33) $display("FAIL const_first_latency: got %0d want 33", q_cyc[0] - c0); else n_pass++;
            n_checks++; if (q_cyc[1] - q_cyc[0] !== 32) $display("FAIL const_period: got %0d want 32", q_cyc[1] - q_cyc[0]); else n_pass++;
            n_checks++; if (q_avg1[0] !== 12'h800) $display("FAIL const_avg1: got %h want 800", q_avg1[0]); else n_pass++;
            n_checks++; if (q_avg2[1] !== 12'h800) $display("FAIL const_avg2: got %h want 800", q_avg2[1]); else n_pass++;
            n_checks++; if (q_clip1[0] !== 1'b0) $display("FAIL const_clip1: got %b want 0", q_clip1[0]); else n_pass++;
            n_checks++; if (q_clip2[0] !== 1'b0) $display("FAIL const_clip2: got %b want 0", q_clip2[0]); else n_pass++;
        end
        idle_gap();
    endtask

    task automatic test_ramp();
        for (int k = 0; k < 16; k++) begin
            s1[k] = 12'h100 + 12'(k);
            s2[k] = 12'h3FF;
        end
        clear_q();
        feed(16);
        n_checks++; if (avg_valid !== 1'b0) $display("FAIL ramp_early_valid: got %b want 0", avg_valid); else n_pass++;
        @(posedge clk50m); #1;
        n_checks++; if (avg_valid !== 1'b1) $display("FAIL ramp_valid: got %b want 1", avg_valid); else n_pass++;
        n_checks++; if (avg_ch1 !== 12'h107) $display("FAIL ramp_avg1: got %h want 107", avg_ch1); else n_pass++;
        n_checks++; if (avg_ch2 !== 12'h3FF) $display("FAIL ramp_avg2: got %h want 3ff", avg_ch2); else n_pass++;
        n_checks++; if (clip_ch1 !== 1'b0) $display("FAIL ramp_clip1: got %b want 0", clip_ch1); else n_pass++;
        n_checks++; if (clip_ch2 !== 1'b0) $display("FAIL ramp_clip2: got %b want 0", clip_ch2); else n_pass++;
        @(negedge clk50m);
        idle_gap();
    endtask

    task automatic test_clip();
        for (int k = 0; k < 32; k++) begin
            s1[k] = (k < 16) ? 12'hFFF : 12'h7FF;
            s2[k] = (k < 16) ? 12'h000 : 12'h7FF;
        end
        clear_q();
        feed(32);
        repeat (2) @(negedge clk50m);
        idle_gap();
        n_checks++;
        if (q_cyc.size() != 2) begin
            $display("FAIL clip_pulses: got %0d want 2", q_cyc.size());
        end else begin
            n_pass++;
            n_checks++; if (q_avg1[0] !== 12'hFFF) $display("FAIL clip_w1_avg1: got %h want fff", q_avg1[0]); else n_pass++;
            n_checks++; if (q_avg2[0] !== 12'h000) $display("FAIL clip_w1_avg2: got %h want 000", q_avg2[0]); else n_pass++;
            n_checks++; if (q_clip1[0] !== 1'b1) $display("FAIL clip_w1_clip1: got %b want 1", q_clip1[0]); else n_pass++;
            n_checks++; if (q_clip2[0] !== 1'b1) $display("FAIL clip_w1_clip2: got %b want 1", q_clip2[0]); else n_pass++;
            n_checks++; if (q_avg1[1] !== 12'h7FF) $display("FAIL clip_w2_avg1: got %h want 7ff", q_avg1[1]); else n_pass++;
            n_checks++; if (q_clip1[1] !== 1'b0) $display("FAIL clip_w2_clip1: got %b want 0", q_clip1[1]); else n_pass++;
            n_checks++; if (q_clip2[1] !== 1'b0) $display("FAIL clip_w2_clip2: got %b want 0", q_clip2[1]); else n_pass++;
        end
    endtask

    task automatic test_enable_drop();
        for (int k = 0; k < 16; k++) begin
            s1[k] = 12'h123;
            s2[k] = 12'h123;
        end
        clear_q();
        feed(9);
        n_checks++; if (busy !== 1'b1) $display("FAIL drop_busy_before: got %b want 1", busy); else n_pass++;
        enable = 1'b0;
        @(posedge clk50m); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL drop_busy_after: got %b want 0", busy); else n_pass++;
        n_checks++; if (avg_ch1 !== 12'h7FF) $display("FAIL drop_hold_avg1: got %h want 7ff", avg_ch1); else n_pass++;
        n_checks++; if (avg_ch2 !== 12'h7FF) $display("FAIL drop_hold_avg2: got %h want 7ff", avg_ch2); else n_pass++;
        repeat (40) @(negedge clk50m);
        n_checks++; if (q_cyc.size() != 0) $display("FAIL drop_no_pulse: got %0d pulses want 0", q_cyc.size()); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            s1[k] = 12'h040;
            s2[k] = 12'h040;
        end
        feed(16);
        n_checks++; if (q_cyc.size() != 0) $display("FAIL reen_early_pulse: got %0d pulses want 0", q_cyc.size()); else n_pass++;
        @(posedge clk50m); #1;
        n_checks++; if (avg_valid !== 1'b1) $display("FAIL reen_valid: got %b want 1", avg_valid); else n_pass++;
        n_checks++; if (avg_ch1 !== 12'h040) $display("FAIL reen_avg1: got %h want 040", avg_ch1); else n_pass++;
        @(negedge clk50m);
        idle_gap();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 16; k++) begin
            s1[k] = 12'h555;
            s2[k] = 12'h555;
        end
        feed(5);
        reset_n = 1'b0;
        #1;
        n_checks++; if (avg_ch1 !== 12'h000) $display("FAIL rst_mid_avg1: got %h want 000", avg_ch1); else n_pass++;
        n_checks++; if (avg_ch2 !== 12'h000) $display("FAIL rst_mid_avg2: got %h want 000", avg_ch2); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (avg_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", avg_valid); else n_pass++;
        enable = 1'b0;
        @(negedge clk50m);
        reset_n = 1'b1;
        @(negedge clk50m);
        clear_q();
        for (int k = 0; k < 16; k++) begin
            s1[k] = 12'h321;
            s2[k] = 12'h321;
        end
        feed(16);
        n_checks++; if (q_cyc.size() != 0) $display("FAIL rst_early_pulse: got %0d pulses want 0", q_cyc.size()); else n_pass++;
        @(posedge clk50m); #1;
        n_checks++; if (avg_valid !== 1'b1) $display("FAIL rst_valid: got %b want 1", avg_valid); else n_pass++;
        n_checks++; if (avg_ch2 !== 12'h321) $display("FAIL rst_avg2: got %h want 321", avg_ch2); else n_pass++;
        @(negedge clk50m);
        idle_gap();
    endtask

    initial begin
        test_reset();
        test_const();
        test_ramp();
        test_clip();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
